// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, states,
// datapath select codes and the packed control word.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_IMM_EX   = 4'd11,
    S_IMM_WB   = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_t;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src_a;
    src_b_t  alu_src_b;
    alu_op_t alu_op;
    pc_src_t pc_source;
    logic    ext_zero;
    logic    retire;
  } ctrl_t;

  // Logical immediates take a zero-extended operand; arithmetic ones sign-extend.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle: IR opcode and zero flag in, control word out.
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             zero;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             ext_zero;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, ext_zero, illegal_op, instr_count
  );

  modport slave (
    output opcode, zero,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, ext_zero, illegal_op, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Moore output decoder: maps the controller state to the datapath control word.
module mips_ctrl_outdec
  import mips_multicycle_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   imm_zext,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_ALU;
      end
      // Speculative branch target computed into ALUOut while the opcode decodes.
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      // pc_write_cond is left ungated; the datapath ANDs it with zero.
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
        ctrl.retire    = 1'b1;
      end
      S_IMM_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_IMM;
        ctrl.ext_zero  = imm_zext;
      end
      S_IMM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.ext_zero  = imm_zext;
        ctrl.retire    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state
// logic, sticky illegal-opcode flag and retired-instruction counter.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)(
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  state_t           state, state_next;
  ctrl_t            ctrl;
  logic             imm_zext;
  logic             illegal;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:                      state_next = S_MEMADR;
          OP_R:                              state_next = S_RTYPE_EX;
          OP_BEQ:                            state_next = S_BRANCH;
          OP_J:                              state_next = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = S_IMM_EX;
          default:                           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_RTYPE_EX: state_next = S_RTYPE_WB;
      S_IMM_EX:   state_next = S_IMM_WB;
      S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BRANCH, S_JUMP, S_IMM_WB:
                  state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_IDLE;
    endcase
  end

  // Extender mode is latched at decode so IMM_EX/IMM_WB outputs depend on state only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_zext <= 1'b0;
      illegal  <= 1'b0;
      count    <= '0;
    end else begin
      if (state == S_DECODE)   imm_zext <= is_zext_op(bus.opcode);
      if (state_next == S_TRAP) illegal <= 1'b1;
      if (ctrl.retire)         count    <= count + 1'b1;
    end
  end

  mips_ctrl_outdec u_outdec (
    .state    (state),
    .imm_zext (imm_zext),
    .ctrl     (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.ext_zero      = ctrl.ext_zero;
  assign bus.illegal_op    = illegal;
  assign bus.instr_count   = count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction phase sequences
// and control words from a behavioural model, random opcode streams, trap and reset.
module tb_mips_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  logic exp_illegal = 1'b0;
  int   zero_mode = 2;
  string phases[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [16:0] observed();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.ext_zero};
  endfunction

  // Expected control word per phase, taken straight from the state table.
  function automatic logic [16:0] phase_word(input string ph, input bit zx);
    logic pw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
    logic rd = 0, rw = 0, sa = 0, ez = 0;
    logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
    case (ph)
      "FETCH":    begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
      "DECODE":   sb = 2'b11;
      "MEMADR":   begin sa = 1; sb = 2'b10; end
      "MEMRD":    begin mr = 1; iord = 1; end
      "MEMWB":    begin rw = 1; m2r = 1; end
      "MEMWR":    begin mw = 1; iord = 1; end
      "RTYPE_EX": begin sa = 1; ao = 2'b10; end
      "RTYPE_WB": begin rw = 1; rd = 1; end
      "BRANCH":   begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      "JUMP":     begin pw = 1; ps = 2'b10; end
      "IMM_EX":   begin sa = 1; sb = 2'b10; ao = 2'b11; ez = zx; end
      "IMM_WB":   begin rw = 1; ez = zx; end
      default:    ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ez};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001010, 6'b001100, 6'b001101};
  endfunction

  function automatic void build_phases(input logic [5:0] op);
    phases = {"FETCH", "DECODE"};
    case (op)
      6'b100011: phases = {phases, "MEMADR", "MEMRD", "MEMWB"};
      6'b101011: phases = {phases, "MEMADR", "MEMWR"};
      6'b000000: phases = {phases, "RTYPE_EX", "RTYPE_WB"};
      6'b000100: phases = {phases, "BRANCH"};
      6'b000010: phases = {phases, "JUMP"};
      6'b001000, 6'b001010, 6'b001100, 6'b001101: phases = {phases, "IMM_EX", "IMM_WB"};
      default: ;
    endcase
  endfunction

  task automatic run_partial(input logic [5:0] op, input int n, input string tag);
    bit zx;
    zx = (op == 6'b001100) || (op == 6'b001101);
    build_phases(op);
    bus.opcode = op;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== phase_word(phases[i], zx)) begin
        errors++;
        $display("FAIL %s cycle %0d (%s): ctrl got %b want %b", tag, i, phases[i],
                 observed(), phase_word(phases[i], zx));
      end
      checks++;
      if (bus.instr_count !== CNT_W'(exp_count) || bus.illegal_op !== exp_illegal) begin
        errors++;
        $display("FAIL %s cycle %0d count/illegal: got %0d/%b want %0d/%b", tag, i,
                 bus.instr_count, bus.illegal_op, exp_count, exp_illegal);
      end
      bus.zero = (zero_mode == 2) ? 1'($urandom) : 1'(zero_mode);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input string tag);
    build_phases(op);
    run_partial(op, phases.size(), tag);
    exp_count = (exp_count + 1) % (1 << CNT_W);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (observed() !== 17'd0) begin
      errors++;
      $display("FAIL %s idle outputs: got %b want 0", tag, observed());
    end
    exp_count = 0;
    exp_illegal = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.opcode = 6'b0;
    bus.zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (observed() !== 17'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b want 0", observed());
    end
    checks++;
    if (bus.instr_count !== '0 || bus.illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset count/illegal: got %0d/%b want 0/0", bus.instr_count, bus.illegal_op);
    end
    release_reset("reset");
  endtask

  task automatic test_lw();
    run_instr(6'b100011, "lw");
    run_instr(6'b101011, "sw");
    run_instr(6'b000000, "rtype");
  endtask

  task automatic test_reset_mid_memrd();
    run_partial(6'b100011, 4, "mid_memrd");
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== 17'd0) begin
      errors++;
      $display("FAIL mid_memrd async drop: got %b want 0", observed());
    end
    checks++;
    if (bus.instr_count !== '0) begin
      errors++;
      $display("FAIL mid_memrd count: got %0d want 0", bus.instr_count);
    end
    release_reset("mid_memrd");
    run_instr(6'b000010, "after_reset_j");
  endtask

  task automatic test_imm();
    run_instr(6'b001101, "ori");
    run_instr(6'b001000, "addi");
    run_instr(6'b001100, "andi");
    run_instr(6'b001010, "slti");
  endtask

  task automatic test_beq();
    zero_mode = 0;
    run_instr(6'b000100, "beq_z0");
    zero_mode = 1;
    run_instr(6'b000100, "beq_z1");
    zero_mode = 2;
  endtask

  task automatic test_random();
    logic [5:0] legal[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                             6'b001000, 6'b001010, 6'b001100, 6'b001101};
    for (int k = 0; k < 40; k++)
      run_instr(legal[$urandom_range(8)], "random");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 17; k++) run_instr(6'b000010, "j_wrap");
    run_instr(6'b000000, "after_wrap");
  endtask

  task automatic test_trap(input logic [5:0] op, input string tag);
    run_partial(op, 2, tag);
    exp_illegal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.opcode = 6'($urandom);
      checks++;
      if (observed() !== 17'd0 || bus.illegal_op !== 1'b1 ||
          bus.instr_count !== CNT_W'(exp_count)) begin
        errors++;
        $display("FAIL %s trap cycle %0d: ctrl %b illegal %b count %0d want 0/1/%0d",
                 tag, i, observed(), bus.illegal_op, bus.instr_count, exp_count);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.illegal_op !== 1'b0 || bus.instr_count !== '0) begin
      errors++;
      $display("FAIL %s trap reset: illegal %b count %0d want 0/0", tag,
               bus.illegal_op, bus.instr_count);
    end
    release_reset(tag);
    run_instr(6'b101011, {tag, "_resume"});
  endtask

  initial begin
    logic [5:0] bad;
    test_reset();
    test_lw();
    test_reset_mid_memrd();
    test_imm();
    test_beq();
    test_random();
    test_back_to_back();
    test_trap(6'b111111, "trap_ff");
    bad = 6'($urandom);
    while (is_legal(bad)) bad = 6'($urandom);
    test_trap(bad, "trap_rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle MIPS-subset datapath.
- Sequences instruction fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Drives every datapath enable and mux select.
- Configures the immediate extender: zero-extend for logical immediates, sign-extend otherwise.
- Sits beside the datapath top; consumes the IR opcode field and the ALU zero flag.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load qualified by zero (branch).
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  register write-data select: 1 = MDR.
- reg_dst  output  1  destination select: 1 = rd, 0 = rt.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A reg.
- alu_src_b  output  2  ALU B select: 00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2.
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = opcode-decoded immediate op.
- pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ext_zero  output  1  extender mode: 1 = zero-extend, 0 = sign-extend.
- illegal_op  output  1  sticky; set on an undefined opcode.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE, illegal_op = 0, instr_count = 0.
  - All outputs are 0 while in IDLE.
- IDLE always moves to FETCH on the next edge.
- Outputs are a pure function of the state register, with one exception: pc_write_cond is additionally not gated by zero; the datapath ANDs it with zero.
- Opcodes:
  - R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010.
  - ADDI = 001000, SLTI = 001010, ANDI = 001100, ORI = 001101.
- States, with asserted outputs and next state:
  - FETCH: mem_read, ir_write, alu_src_b = 01, alu_op = 00, pc_write, pc_source = 00. Next: DECODE.
  - DECODE: alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next by opcode:
    - LW/SW → MEMADR
    - R → RTYPE_EX
    - BEQ → BRANCH
    - J → JUMP
    - ADDI/SLTI/ANDI/ORI → IMM_EX
    - other → TRAP
  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00, ext_zero = 0. Next: LW → MEMRD, SW → MEMWR.
  - MEMRD: mem_read, iord. Next: MEMWB.
  - MEMWB: reg_write, mem_to_reg, reg_dst = 0. Retire. Next: FETCH.
  - MEMWR: mem_write, iord. Retire. Next: FETCH.
  - RTYPE_EX: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next: RTYPE_WB.
  - RTYPE_WB: reg_write, reg_dst = 1. Retire. Next: FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond, pc_source = 01. Retire. Next: FETCH.
  - JUMP: pc_write, pc_source = 10. Retire. Next: FETCH.
  - IMM_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 11. ext_zero = 1 iff opcode is ANDI or ORI; 0 for ADDI/SLTI. Next: IMM_WB.
  - IMM_WB: reg_write, reg_dst = 0, ext_zero held as in IMM_EX. Retire. Next: FETCH.
  - TRAP: sets illegal_op; all enables 0; stays in TRAP until reset.
- ext_zero is 0 in every state other than IMM_EX/IMM_WB.
- Retire: instr_count increments by 1 on the edge leaving a retiring state. It wraps modulo 2^CNT_W with no saturation.
- Latency, FETCH to next FETCH:
  - LW 5 cycles.
  - SW, R, ADDI, SLTI, ANDI, ORI 4 cycles.
  - BEQ, J 3 cycles.
- The zero input is ignored in every state.
- opcode is sampled only in DECODE and MEMADR (IR is stable there).
- Reset mid-instruction:
  - Returns to IDLE immediately; a partially completed instruction is not counted.
  - Any write strobes drop asynchronously.
- Unused 2-bit encodings never appear; an illegal state register value recovers to IDLE.

Decomposition:
- Shared package/header holds:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI)
  - state encodings (4-bit)
  - alu_op, alu_src_b and pc_source encodings
- One sub-module, mips_ctrl_outdec: combinational state → control-word decoder.
- State register, next-state logic, sticky flag and counter stay in the top.

Test Plan:
- Reset asserted mid-MEMRD → all outputs 0 same cycle; after release: IDLE then FETCH; mem_read = ir_write = pc_write = 1 in FETCH.
- opcode = 100011 (LW) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write = 1, mem_to_reg = 1 in cycle 5; instr_count 0 → 1.
- opcode = 001101 (ORI) → ext_zero = 1 in IMM_EX and IMM_WB; opcode = 001000 (ADDI) → ext_zero = 0 throughout; both take 4 cycles.
- opcode = 000100 (BEQ) with zero = 0 and zero = 1 → identical 3-cycle sequence, pc_write_cond = 1 and pc_source = 01 in BRANCH.
- opcode = 111111 → TRAP; illegal_op = 1 and stays set; instr_count frozen; reset clears both.
- CNT_W = 4, 16 back-to-back J instructions → instr_count wraps 15 → 0.
